// File: rtl/operand_regfile.sv
// operand_regfile: 2-read/1-write register file feeding the ALU operands, r0 hardwired to zero.
// Optional write-through bypass on both read ports when REGFILE_BYPASS_EN is defined.
module operand_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);
    localparam int NREG = 1 << ADDR_WIDTH;

    // r0 has no storage; the array starts at r1
    logic [DATA_WIDTH-1:0] regs_q [1:NREG-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NREG-1];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] stored_a, stored_b;

    assign wr_en = ctrl_writeEnable && !ctrl_reset && (ctrl_writeReg != '0);

    always_comb begin
        for (int i = 1; i < NREG; i++)
            regs_d[i] = ctrl_reset ? '0
                      : (wr_en && ctrl_writeReg == ADDR_WIDTH'(i)) ? data_writeReg
                      : regs_q[i];
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    assign stored_a = (ctrl_readRegA == '0) ? '0 : regs_q[ctrl_readRegA];
    assign stored_b = (ctrl_readRegB == '0) ? '0 : regs_q[ctrl_readRegB];

`ifdef REGFILE_BYPASS_EN
    assign data_readRegA = (wr_en && ctrl_writeReg == ctrl_readRegA) ? data_writeReg : stored_a;
    assign data_readRegB = (wr_en && ctrl_writeReg == ctrl_readRegB) ? data_writeReg : stored_b;
`else
    assign data_readRegA = stored_a;
    assign data_readRegB = stored_b;
`endif
endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: directed stimulus with a per-cycle reference-model compare plus literal checks.
module tb_operand_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wr = '0;
    logic [31:0] wd = '0;
    logic [4:0]  ra = '0;
    logic [4:0]  rb = '0;
    logic [31:0] qa, qb;
    logic [31:0] model [0:31];
    logic        armed = 1'b0;
    int          tests = 0;
    int          fails = 0;

    operand_regfile dut (
        .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
        .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(qa), .data_readRegB(qb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && wr != 5'd0 && wr == idx) return wd;
`endif
        return model[idx];
    endfunction

    // Reference: registers hold the last committed write; reset clears everything
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
        end else if (we && wr != 5'd0) begin
            model[wr] <= wd;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_portA", qa, exp_rd(ra));
            check("model_portB", qb, exp_rd(rb));
        end
    end

    task automatic drive(input logic r, input logic e, input logic [4:0] w, input logic [31:0] d,
                         input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        #1;
        rst = r; we = e; wr = w; wd = d; ra = a; rb = b;
        @(negedge clk);
    endtask

    logic [32:0] sum;
    logic        ovf;

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        armed = 1'b1;
        check("reset_r0", qa, 32'h0);

        // reset clear with a discarded same-cycle write
        drive(0, 1, 5, 32'hDEADBEEF, 5, 5);
        drive(0, 0, 0, 0, 5, 6);
        check("r5_written", qa, 32'hDEADBEEF);
        drive(1, 1, 6, 32'h1234, 5, 6);
        check("r5_pre_reset", qa, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 5, 6);
        check("r5_cleared_A", qa, 32'h0);
        check("r6_cleared_B", qb, 32'h0);
        drive(0, 0, 0, 0, 6, 5);
        check("r6_cleared_A", qa, 32'h0);
        check("r5_cleared_B", qb, 32'h0);

        // write then read every register on both ports
        for (int i = 1; i < 32; i++) drive(0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
            check("all_A", qa, 32'(i) * 32'h01010101);
            check("all_B", qb, 32'(31 - i) * 32'h01010101);
        end

        // r0 protection
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("r0_protect", qa, 32'h0);

        // enable gating
        drive(0, 1, 7, 32'h00000055, 7, 7);
        drive(0, 0, 7, 32'hAAAAAAAA, 7, 7);
        drive(0, 0, 0, 0, 7, 7);
        check("en_gate_A", qa, 32'h00000055);
        check("en_gate_B", qb, 32'h00000055);

        // same-cycle read/write
        drive(0, 1, 9, 32'h11111111, 0, 0);
        drive(0, 1, 9, 32'h22222222, 9, 9);
`ifdef REGFILE_BYPASS_EN
        check("rdw_A_same", qa, 32'h22222222);
        check("rdw_B_same", qb, 32'h22222222);
`else
        check("rdw_A_same", qa, 32'h11111111);
        check("rdw_B_same", qb, 32'h11111111);
`endif
        drive(0, 0, 0, 0, 9, 9);
        check("rdw_A_after", qa, 32'h22222222);
        check("rdw_B_after", qb, 32'h22222222);

        // reset cycle never bypasses
        drive(1, 1, 9, 32'h33333333, 9, 0);
        check("no_bypass_in_reset", qa, 32'h22222222);
        drive(0, 0, 0, 0, 9, 0);
        check("post_reset_r9", qa, 32'h0);

        // ALU feed: ADD of the two operands overflows into the sign bit
        drive(0, 1, 1, 32'h7FFFFFFF, 0, 0);
        drive(0, 1, 2, 32'h00000001, 0, 0);
        drive(0, 0, 0, 0, 1, 2);
        sum = {1'b0, qa} + {1'b0, qb};
        ovf = (qa[31] == qb[31]) && (sum[31] != qa[31]);
        check("alu_add", sum[31:0], 32'h80000000);
        check("alu_ovf", {31'h0, ovf}, 32'h1);

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Architectural register file directly upstream of the ALU in the execute path.
- Holds 2^ADDR_WIDTH general-purpose registers, each DATA_WIDTH bits wide.
- Provides two read ports whose outputs drive the ALU operand A and operand B inputs.
- Provides one write port, driven by the writeback of ALU results.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; the file holds 2^ADDR_WIDTH registers, including r0.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- ctrl_reset  input  1  synchronous, active-high reset; sampled on the rising clock edge.
- ctrl_writeEnable  input  1  when 1, the write is committed at the next rising edge.
- ctrl_writeReg  input  ADDR_WIDTH  destination register index.
- data_writeReg  input  DATA_WIDTH  write data.
- ctrl_readRegA  input  ADDR_WIDTH  read port A index; feeds ALU operand A.
- ctrl_readRegB  input  ADDR_WIDTH  read port B index; feeds ALU operand B.
- data_readRegA  output  DATA_WIDTH  contents of register ctrl_readRegA.
- data_readRegB  output  DATA_WIDTH  contents of register ctrl_readRegB.

Behaviour:
- Storage: registers r1..r(2^ADDR_WIDTH-1) are flip-flops. r0 has no storage and always reads 0.
- Reset (synchronous):
  - When ctrl_reset=1 at a rising edge, every stored register becomes 0 at that edge.
  - Reset has priority over any write presented in the same cycle; that write is discarded.
  - Reset asserted in the middle of a write sequence drops only the write in the reset cycle. Writes in earlier cycles were already committed and are then cleared by the reset.
  - After reset both read outputs are 0 for every index.
- Write:
  - When ctrl_writeEnable=1, ctrl_reset=0, and ctrl_writeReg!=0, register[ctrl_writeReg] is loaded with data_writeReg at the rising edge. Write latency is 1 edge.
  - A write to r0 is silently ignored and r0 stays 0.
  - When ctrl_writeEnable=0, no register changes, whatever the other write inputs hold.
  - Data is stored verbatim, with no sign or width manipulation.
- Read:
  - Reads are purely combinational from index to data, with zero-cycle latency.
  - data_readRegX = 0 if ctrl_readRegX==0; otherwise it equals the stored register[ctrl_readRegX].
  - Both ports may address the same register simultaneously and both return the same value.
- Read-during-write (same cycle, same nonzero index, no bypass): the read returns the old value; the new value is visible from the cycle after the edge.
- Outputs are never X after the first reset. Before the first reset the storage contents are unspecified.
- Every index is valid; there are no out-of-range conditions.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass on both read ports. If ctrl_writeEnable=1, ctrl_reset=0, ctrl_writeReg!=0, and ctrl_writeReg==ctrl_readRegX, then data_readRegX = data_writeReg in that same cycle.
  - The bypass is combinational.
  - r0 is never bypassed.
  - No bypass occurs while ctrl_reset=1.
  - Lets the ALU consume a writeback result without a stall cycle.
- Not defined: no bypass logic; read-during-write returns the pre-edge value as described in Behaviour.
- Storage behaviour is identical in both builds.

Test Plan:
- Reset clear: write 32'hDEADBEEF to r5, then hold ctrl_reset=1 for one edge together with a write of 32'h1234 to r6 -> afterwards r5=0 and r6=0 on both ports.
- Write/read all: write value (i*32'h01010101) to each ri, i=1..31 -> reading each index on both ports returns that value; r0 reads 0.
- r0 protection: write 32'hFFFFFFFF to r0 with enable=1 -> data_readRegA=0 for ctrl_readRegA=0.
- Enable gating: write r7=32'h00000055, then present ctrl_writeReg=7 and data=32'hAAAAAAAA with enable=0 -> r7 still reads 32'h00000055.
- Same-cycle read/write: r9=32'h11111111; in one cycle write r9=32'h22222222 while both ports read r9 -> without REGFILE_BYPASS_EN both return 32'h11111111 before the edge and 32'h22222222 after; with it both return 32'h22222222 immediately.
- ALU feed: write r1=32'h7FFFFFFF and r2=32'h00000001, read A=r1 and B=r2, feed the ALU with opcode ADD -> result 32'h80000000 with overflow=1.
